session_controller: RTL and testbench

Parametrised top-level session FSM for the game platform: login through access control, an N-entry mode menu (game, scoreboard, and future apps), per-mode handoff, and logout. It sits between the debounced button/switch front end and the access-control, LCD, LED and mode blocks. It adds three things: button edge detection, a failed-password lockout and a menu inactivity timeout.

---
 rtl/session_pkg.sv | 28 ++
 rtl/btn_edge_detect.sv | 24 ++
 rtl/session_controller.sv | 188 ++++++++++++++++++
 tb/tb_session_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/session_pkg.sv
// Shared types and output codes for the session controller and its helpers.
package session_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAuth,
    StLockout,
    StMenu,
    StRun
  } state_e;

  localparam logic [2:0] LCD_WELCOME  = 3'd0;
  localparam logic [2:0] LCD_PASSWORD = 3'd1;
  localparam logic [2:0] LCD_INVALID  = 3'd2;
  localparam logic [2:0] LCD_MENU     = 3'd3;
  localparam logic [2:0] LCD_RUNNING  = 3'd4;
  localparam logic [2:0] LCD_LOCKED   = 3'd5;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_RED   = 2'd1;
  localparam logic [1:0] LED_GREEN = 2'd2;
  localparam logic [1:0] LED_AMBER = 2'd3;

  localparam int unsigned ROUTE_SELF  = 0;
  localparam int unsigned ROUTE_AUTH  = 1;
  localparam int unsigned ROUTE_MODE0 = 2;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for level buttons. Resets to all-ones so a button held
// through reset release does not produce an event.
module btn_edge_detect #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= '1;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/session_controller.sv
// Top-level session FSM: login via access control, mode menu, per-mode handoff,
// failed-password lockout and menu inactivity timeout.
module session_controller
  import session_pkg::*;
#(
  parameter int unsigned NUM_MODES      = 2,
  parameter int unsigned UID_W          = 16,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  localparam int unsigned RouteW = $clog2(NUM_MODES + 2),
  localparam int unsigned ModeW  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        btn_i,
  input  logic              auth_done_i,
  input  logic              auth_ok_i,
  input  logic [UID_W-1:0]  auth_uid_i,
  input  logic [NUM_MODES-1:0] mode_done_i,
  output logic [RouteW-1:0] btn_route_o,
  output logic              sw_en_o,
  output logic [2:0]        lcd_msg_o,
  output logic [1:0]        led_state_o,
  output logic [UID_W-1:0]  userid_o,
  output logic [ModeW-1:0]  mode_sel_o,
  output logic              mode_start_o,
  output logic              timeout_evt_o
);

  localparam int unsigned AttW     = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TimerMax = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = ($clog2(TimerMax) < 1) ? 1 : $clog2(TimerMax);

  logic [2:0] rise;

  btn_edge_detect #(
    .Width(3)
  ) u_btn_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (btn_i),
    .rise_o (rise)
  );

  state_e             state_q, state_d;
  logic [AttW-1:0]    attempts_q, attempts_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [ModeW-1:0]   mode_sel_q, mode_sel_d;
  logic [UID_W-1:0]   userid_q, userid_d;
  logic               fail_q, fail_d;
  logic               mode_start_q, mode_start_d;
  logic               timeout_evt_q, timeout_evt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      attempts_q    <= '0;
      timer_q       <= '0;
      mode_sel_q    <= '0;
      userid_q      <= '0;
      fail_q        <= 1'b0;
      mode_start_q  <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      attempts_q    <= attempts_d;
      timer_q       <= timer_d;
      mode_sel_q    <= mode_sel_d;
      userid_q      <= userid_d;
      fail_q        <= fail_d;
      mode_start_q  <= mode_start_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    attempts_d    = attempts_q;
    mode_sel_d    = mode_sel_q;
    userid_d      = userid_q;
    fail_d        = fail_q;
    mode_start_d  = 1'b0;
    timeout_evt_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise[0]) begin
          state_d = StAuth;
          fail_d  = 1'b0;
        end
      end
      StAuth: begin
        // A completed access check outranks a cancel in the same cycle.
        if (auth_done_i) begin
          if (auth_ok_i) begin
            state_d    = StMenu;
            userid_d   = auth_uid_i;
            attempts_d = '0;
            mode_sel_d = '0;
          end else begin
            attempts_d = attempts_q + AttW'(1);
            fail_d     = 1'b1;
            if (attempts_q == AttW'(MAX_ATTEMPTS - 1)) begin
              state_d = StLockout;
            end
          end
        end else if (rise[0]) begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (timer_q == TimerW'(LOCK_CYCLES - 1)) begin
          state_d    = StIdle;
          attempts_d = '0;
        end
      end
      StMenu: begin
        if (rise[0]) begin
          state_d  = StIdle;
          userid_d = '0;
        end else if (rise[2]) begin
          state_d      = StRun;
          mode_start_d = 1'b1;
        end else if (rise[1]) begin
          mode_sel_d = (mode_sel_q == ModeW'(NUM_MODES - 1)) ? '0 : mode_sel_q + ModeW'(1);
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 2)) begin
          // Timer reaches TIMEOUT_CYCLES-1 on this edge, which is the logout edge.
          state_d       = StIdle;
          userid_d      = '0;
          timeout_evt_d = 1'b1;
        end
      end
      StRun: begin
        if (mode_done_i[mode_sel_q]) begin
          state_d = StMenu;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q || (state_q == StMenu && |rise)) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_comb begin
    btn_route_o = RouteW'(ROUTE_SELF);
    sw_en_o     = 1'b0;
    lcd_msg_o   = LCD_WELCOME;
    led_state_o = LED_OFF;
    unique case (state_q)
      StIdle: ;
      StAuth: begin
        btn_route_o = RouteW'(ROUTE_AUTH);
        sw_en_o     = 1'b1;
        lcd_msg_o   = fail_q ? LCD_INVALID : LCD_PASSWORD;
        led_state_o = LED_RED;
      end
      StLockout: begin
        lcd_msg_o   = LCD_LOCKED;
        led_state_o = LED_AMBER;
      end
      StMenu: begin
        lcd_msg_o   = LCD_MENU;
        led_state_o = LED_GREEN;
      end
      StRun: begin
        btn_route_o = RouteW'(ROUTE_MODE0) + RouteW'(mode_sel_q);
        lcd_msg_o   = LCD_RUNNING;
        led_state_o = LED_GREEN;
      end
      default: ;
    endcase
  end

  assign userid_o      = userid_q;
  assign mode_sel_o    = mode_sel_q;
  assign mode_start_o  = mode_start_q;
  assign timeout_evt_o = timeout_evt_q;

endmodule

// File: tb/tb_session_controller.sv
// Directed bench for session_controller with small lockout/timeout parameters.
module tb_session_controller;

  localparam int unsigned NumModes = 3;
  localparam int unsigned UidW     = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          btn;
  logic                auth_done;
  logic                auth_ok;
  logic [UidW-1:0]     auth_uid;
  logic [NumModes-1:0] mode_done;
  logic [2:0]          btn_route;
  logic                sw_en;
  logic [2:0]          lcd_msg;
  logic [1:0]          led_state;
  logic [UidW-1:0]     userid;
  logic [1:0]          mode_sel;
  logic                mode_start;
  logic                timeout_evt;

  int n_tests = 0;
  int n_fail  = 0;

  session_controller #(
    .NUM_MODES      (NumModes),
    .UID_W          (UidW),
    .MAX_ATTEMPTS   (3),
    .LOCK_CYCLES    (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_i         (btn),
    .auth_done_i   (auth_done),
    .auth_ok_i     (auth_ok),
    .auth_uid_i    (auth_uid),
    .mode_done_i   (mode_done),
    .btn_route_o   (btn_route),
    .sw_en_o       (sw_en),
    .lcd_msg_o     (lcd_msg),
    .led_state_o   (led_state),
    .userid_o      (userid),
    .mode_sel_o    (mode_sel),
    .mode_start_o  (mode_start),
    .timeout_evt_o (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press for one edge, then release for one edge.
  task automatic press(input int b);
    btn[b] = 1'b1;
    tick();
    btn[b] = 1'b0;
  endtask

  task automatic auth(input logic ok, input logic [UidW-1:0] uid);
    auth_done = 1'b1;
    auth_ok   = ok;
    auth_uid  = uid;
    tick();
    auth_done = 1'b0;
    auth_ok   = 1'b0;
    auth_uid  = '0;
  endtask

  initial begin
    rst = 1'b0; btn = '0; auth_done = 1'b0; auth_ok = 1'b0; auth_uid = '0; mode_done = '0;
    repeat (3) tick();
    check("rst_lcd", lcd_msg, 0);
    check("rst_led", led_state, 0);
    check("rst_route", btn_route, 0);
    check("rst_sw_en", sw_en, 0);
    check("rst_userid", userid, 0);
    check("rst_mode_sel", mode_sel, 0);
    check("rst_pulses", {mode_start, timeout_evt}, 0);
    rst = 1'b1;
    tick();

    // Login
    press(0);
    check("auth_lcd", lcd_msg, 1);
    check("auth_led", led_state, 1);
    check("auth_route", btn_route, 1);
    check("auth_sw_en", sw_en, 1);
    tick();
    auth(1'b1, 16'h1234);
    check("login_lcd", lcd_msg, 3);
    check("login_led", led_state, 2);
    check("login_userid", userid, 16'h1234);
    check("login_mode_sel", mode_sel, 0);
    check("login_sw_en", sw_en, 0);

    // Menu wrap and enter-over-next priority
    press(1); tick(); check("wrap_1", mode_sel, 1);
    press(1); tick(); check("wrap_2", mode_sel, 2);
    press(1); tick(); check("wrap_0", mode_sel, 0);
    btn = 3'b110;
    tick();
    btn = 3'b000;
    check("enter_lcd", lcd_msg, 4);
    check("enter_route", btn_route, 2);
    check("enter_mode_sel", mode_sel, 0);
    check("mode_start_hi", mode_start, 1);
    tick();
    check("mode_start_lo", mode_start, 0);

    // Back to menu, select mode 2 and run it
    mode_done = 3'b001; tick(); mode_done = '0;
    check("done0_lcd", lcd_msg, 3);
    press(1); tick();
    press(1); tick();
    press(2);
    check("run2_route", btn_route, 4);
    tick();
    mode_done = 3'b001; tick(); mode_done = '0;
    check("other_done_ign", lcd_msg, 4);
    press(0); tick();
    check("run_btn_ign", lcd_msg, 4);
    check("run_userid", userid, 16'h1234);
    mode_done = 3'b100; tick(); mode_done = '0;
    check("done2_lcd", lcd_msg, 3);
    check("done2_route", btn_route, 0);
    check("done2_mode_sel", mode_sel, 2);

    // Timeout with restart: btn1 at cycle 14 after menu entry
    repeat (13) tick();
    btn[1] = 1'b1; tick(); btn[1] = 1'b0;
    check("restart_lcd", lcd_msg, 3);
    check("restart_wrap", mode_sel, 0);
    repeat (14) tick();
    check("pre_timeout_lcd", lcd_msg, 3);
    check("pre_timeout_evt", timeout_evt, 0);
    tick();
    check("timeout_lcd", lcd_msg, 0);
    check("timeout_evt_hi", timeout_evt, 1);
    check("timeout_userid", userid, 0);
    tick();
    check("timeout_evt_lo", timeout_evt, 0);

    // Lockout
    press(0); tick();
    auth(1'b0, '0);
    check("fail1_lcd", lcd_msg, 2);
    check("fail1_led", led_state, 1);
    auth(1'b0, '0);
    check("fail2_lcd", lcd_msg, 2);
    auth(1'b0, '0);
    check("lock_lcd", lcd_msg, 5);
    check("lock_led", led_state, 3);
    check("lock_route", btn_route, 0);
    btn[0] = 1'b1; tick(); btn[0] = 1'b0;
    check("lock_btn_ign", lcd_msg, 5);
    repeat (6) tick();
    check("lock_k7", lcd_msg, 5);
    tick();
    check("lock_exit_lcd", lcd_msg, 0);
    check("lock_exit_led", led_state, 0);

    // Fresh AUTH after lockout shows the password prompt again
    press(0);
    check("reauth_lcd", lcd_msg, 1);
    tick();
    auth(1'b0, '0);
    check("reauth_fail_lcd", lcd_msg, 2);
    auth(1'b1, 16'hBEEF);
    check("relogin_userid", userid, 16'hBEEF);
    press(2);
    check("run0_route", btn_route, 2);
    tick();

    // Reset mid-RUN with btn0 held
    btn[0] = 1'b1;
    rst = 1'b0;
    tick();
    check("midrst_lcd", lcd_msg, 0);
    check("midrst_route", btn_route, 0);
    check("midrst_userid", userid, 0);
    check("midrst_led", led_state, 0);
    rst = 1'b1;
    tick(); tick();
    check("held_no_event", lcd_msg, 0);
    btn[0] = 1'b0;
    tick();
    press(0);
    check("repress_lcd", lcd_msg, 1);
    tick();

    // auth_done beats a simultaneous cancel; then logout
    btn[0] = 1'b1;
    auth(1'b1, 16'h00A5);
    btn[0] = 1'b0;
    check("auth_prio_lcd", lcd_msg, 3);
    tick();
    press(0);
    check("logout_lcd", lcd_msg, 0);
    check("logout_userid", userid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
